// File: rtl/fetch_controller_if.sv
// Front-end fetch bus: memory port, predictor query, decoder handoff and ROB redirect.
interface fetch_controller_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_ready;
   logic              mem_resp_valid;
   logic [INST_W-1:0] mem_resp_inst;
   logic [ADDR_W-1:0] query_pc;
   logic [INST_W-1:0] query_inst;
   logic              predicted_jump;
   logic [ADDR_W-1:0] predicted_imm;
   logic              out_valid;
   logic [INST_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;
   logic              out_pred_jump;
   logic              dec_ready;
   logic              rollback_valid;
   logic [ADDR_W-1:0] rollback_pc;

   modport master (
      output mem_req_valid, mem_req_addr, query_pc, query_inst,
             out_valid, out_inst, out_pc, out_pred_jump,
      input  mem_req_ready, mem_resp_valid, mem_resp_inst, predicted_jump,
             predicted_imm, dec_ready, rollback_valid, rollback_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, query_pc, query_inst,
             out_valid, out_inst, out_pc, out_pred_jump,
      output mem_req_ready, mem_resp_valid, mem_resp_inst, predicted_jump,
             predicted_imm, dec_ready, rollback_valid, rollback_pc
   );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding memory request, predictor lookup,
// decoder handoff and ROB rollback redirect.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_REQ   | presenting fetch request at pc
//   S_WAIT  | request accepted, waiting for the instruction
//   S_ISSUE | instruction held for the decoder, predictor queried
//   S_DRAIN | redirected while a request is in flight; discard its response
module fetch_controller #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rdy,
   fetch_controller_if.master  bus
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [INST_W-1:0] inst_reg, inst_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         inst_reg <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         inst_reg <= inst_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      inst_nxt  = inst_reg;
      if (rdy) begin
         if (bus.rollback_valid) begin
            // Redirect wins over everything; only an in-flight request forces a drain.
            pc_nxt = bus.rollback_pc;
            unique case (state)
               S_REQ:   state_nxt = bus.mem_req_ready  ? S_DRAIN : S_REQ;
               S_WAIT:  state_nxt = bus.mem_resp_valid ? S_REQ   : S_DRAIN;
               S_ISSUE: state_nxt = S_REQ;
               S_DRAIN: state_nxt = bus.mem_resp_valid ? S_REQ   : S_DRAIN;
               default: state_nxt = S_REQ;
            endcase
         end else begin
            unique case (state)
               S_REQ: begin
                  if (bus.mem_req_ready) state_nxt = S_WAIT;
               end
               S_WAIT: begin
                  if (bus.mem_resp_valid) begin
                     inst_nxt  = bus.mem_resp_inst;
                     state_nxt = S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (bus.dec_ready) begin
                     pc_nxt    = bus.predicted_jump ? pc + bus.predicted_imm
                                                    : pc + ADDR_W'(4);
                     state_nxt = S_REQ;
                  end
               end
               S_DRAIN: begin
                  if (bus.mem_resp_valid) state_nxt = S_REQ;
               end
               default: state_nxt = S_REQ;
            endcase
         end
      end
   end

   logic in_req, in_issue;
   assign in_req   = (state == S_REQ);
   assign in_issue = (state == S_ISSUE);

   assign bus.mem_req_valid = in_req;
   assign bus.mem_req_addr  = in_req   ? pc       : '0;
   assign bus.query_pc      = in_issue ? pc       : '0;
   assign bus.query_inst    = in_issue ? inst_reg : '0;
   assign bus.out_valid     = in_issue;
   assign bus.out_inst      = in_issue ? inst_reg : '0;
   assign bus.out_pc        = in_issue ? pc       : '0;
   assign bus.out_pred_jump = in_issue & bus.predicted_jump;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: fetch flow, prediction, stall, rollback, wrap, rdy hold.
module tb_fetch_controller;
   logic clk = 1'b0;
   logic rst_n;
   logic rdy;
   int   total = 0;
   int   bad   = 0;

   fetch_controller_if #(.ADDR_W(32), .INST_W(32)) bus ();

   fetch_controller #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rdy   (rdy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rdy   = 1'b1;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_inst  = '0;
      bus.predicted_jump = 1'b0;
      bus.predicted_imm  = '0;
      bus.dec_ready      = 1'b1;
      bus.rollback_valid = 1'b0;
      bus.rollback_pc    = '0;

      // Reset
      tick(); tick();
      check("rst_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("rst_req_addr",  bus.mem_req_addr, 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_query_pc",  bus.query_pc, 32'h0);
      check("rst_out_inst",  bus.out_inst, 32'h0);
      rst_n = 1'b1;

      // Basic fetch at pc=0
      tick();
      check("wait_req_valid", 32'(bus.mem_req_valid), 32'd0);
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'h00000013;
      tick();
      bus.mem_resp_valid = 1'b0;
      check("iss0_valid", 32'(bus.out_valid), 32'd1);
      check("iss0_pc",    bus.out_pc, 32'h0);
      check("iss0_inst",  bus.out_inst, 32'h00000013);
      check("iss0_pj",    32'(bus.out_pred_jump), 32'd0);
      check("iss0_qinst", bus.query_inst, 32'h00000013);
      tick();
      check("req4_valid", 32'(bus.mem_req_valid), 32'd1);
      check("req4_addr",  bus.mem_req_addr, 32'h4);

      // pc=4 plain, then JAL at pc=8
      tick();
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'h00000013;
      tick();
      bus.mem_resp_valid = 1'b0;
      tick();
      check("req8_addr", bus.mem_req_addr, 32'h8);
      tick();
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'h0100006F;
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.predicted_jump = 1'b1; bus.predicted_imm = 32'd16;
      #1;
      check("jal_pj",    32'(bus.out_pred_jump), 32'd1);
      check("jal_inst",  bus.out_inst, 32'h0100006F);
      check("jal_qpc",   bus.query_pc, 32'h8);
      tick();
      bus.predicted_jump = 1'b0; bus.predicted_imm = '0;
      check("jal_next_addr", bus.mem_req_addr, 32'd24);

      // Decoder stall for 5 cycles in ISSUE
      tick();
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'hAAAA0001;
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.dec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", 32'(bus.out_valid), 32'd1);
         check("stall_inst",  bus.out_inst, 32'hAAAA0001);
         check("stall_pc",    bus.out_pc, 32'd24);
         check("stall_noreq", 32'(bus.mem_req_valid), 32'd0);
      end
      bus.dec_ready = 1'b1;
      tick();
      check("stall_adv_addr", bus.mem_req_addr, 32'd28);

      // Rollback in WAIT, response 3 cycles later is discarded
      tick();
      bus.rollback_valid = 1'b1; bus.rollback_pc = 32'h100;
      tick();
      bus.rollback_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("drain_noout", 32'(bus.out_valid), 32'd0);
         check("drain_noreq", 32'(bus.mem_req_valid), 32'd0);
         tick();
      end
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'hBAD00000;
      tick();
      bus.mem_resp_valid = 1'b0;
      check("drain_out_after", 32'(bus.out_valid), 32'd0);
      check("rb_wait_valid", 32'(bus.mem_req_valid), 32'd1);
      check("rb_wait_addr",  bus.mem_req_addr, 32'h100);

      // Rollback with response in WAIT
      tick();
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'hDEAD0000;
      bus.rollback_valid = 1'b1; bus.rollback_pc = 32'h200;
      tick();
      bus.mem_resp_valid = 1'b0; bus.rollback_valid = 1'b0;
      check("rb_resp_valid", 32'(bus.mem_req_valid), 32'd1);
      check("rb_resp_addr",  bus.mem_req_addr, 32'h200);
      check("rb_resp_noout", 32'(bus.out_valid), 32'd0);

      // Rollback in ISSUE with dec_ready high
      tick();
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'h00000013;
      tick();
      bus.mem_resp_valid = 1'b0;
      check("rb_iss_valid", 32'(bus.out_valid), 32'd1);
      bus.rollback_valid = 1'b1; bus.rollback_pc = 32'h300;
      tick();
      bus.rollback_valid = 1'b0;
      check("rb_iss_addr", bus.mem_req_addr, 32'h300);

      // Redirect to top of address space while request not accepted
      bus.mem_req_ready = 1'b0;
      bus.rollback_valid = 1'b1; bus.rollback_pc = 32'hFFFFFFFC;
      tick();
      bus.rollback_valid = 1'b0;
      check("rb_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("rb_req_addr",  bus.mem_req_addr, 32'hFFFFFFFC);
      bus.mem_req_ready = 1'b1;
      tick();

      // rdy low for 3 cycles in WAIT with a response pulse
      rdy = 1'b0;
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'h12345678;
      tick();
      bus.mem_resp_valid = 1'b0;
      tick(); tick();
      rdy = 1'b1;
      check("rdy_hold_noout", 32'(bus.out_valid), 32'd0);
      check("rdy_hold_noreq", 32'(bus.mem_req_valid), 32'd0);
      tick();
      check("rdy_still_wait", 32'(bus.out_valid), 32'd0);
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'h00000013;
      tick();
      bus.mem_resp_valid = 1'b0;
      check("wrap_iss_pc",   bus.out_pc, 32'hFFFFFFFC);
      check("wrap_iss_inst", bus.out_inst, 32'h00000013);
      tick();
      check("wrap_addr", bus.mem_req_addr, 32'h0);
      check("wrap_valid", 32'(bus.mem_req_valid), 32'd1);

      // Rollback in REQ with request accepted drains the in-flight fetch
      bus.rollback_valid = 1'b1; bus.rollback_pc = 32'h400;
      tick();
      bus.rollback_valid = 1'b0;
      check("rb_acc_noreq", 32'(bus.mem_req_valid), 32'd0);
      bus.mem_resp_valid = 1'b1; bus.mem_resp_inst = 32'hBAD00001;
      tick();
      bus.mem_resp_valid = 1'b0;
      check("rb_acc_noout", 32'(bus.out_valid), 32'd0);
      check("rb_acc_addr",  bus.mem_req_addr, 32'h400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch for the front end. Owns the PC, issues one fetch request at a time to the memory/icache port, and feeds each returned instruction to the branch predictor.
- Hands each instruction, its PC and the prediction to the decoder through a valid/ready handshake.
- Redirects on ROB rollback, including discarding a fetch that is already in flight.

Parameters:
- RESET_PC, 32'h0, PC value after reset.
- ADDR_W, 32, address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rdy  in  1  global enable; when low, all state holds
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  ADDR_W  fetch address
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_resp_valid  in  1  one-cycle pulse, instruction returned
- mem_resp_inst  in  INST_W  returned instruction
- query_pc  out  ADDR_W  PC presented to the predictor
- query_inst  out  INST_W  instruction presented to the predictor
- predicted_jump  in  1  predictor says taken (combinational from query)
- predicted_imm  in  ADDR_W  predictor target offset
- out_valid  out  1  instruction available to the decoder
- out_inst  out  INST_W  instruction
- out_pc  out  ADDR_W  instruction PC
- out_pred_jump  out  1  prediction carried with the instruction
- dec_ready  in  1  decoder accepts this cycle
- rollback_valid  in  1  ROB misprediction redirect
- rollback_pc  in  ADDR_W  redirect target

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc=RESET_PC, inst_reg=0, state=REQ.
  - All outputs read 0 except mem_req_valid, which reads 1 from the first cycle after reset (state REQ).
  - Reset overrides rollback and rdy.
- rdy low: no state, PC or register update. Outputs hold their values; handshakes completing in that cycle are ignored.
- States: REQ, WAIT, ISSUE, DRAIN. All outputs are decoded from registered state and registers.
- REQ:
  - mem_req_valid=1, mem_req_addr=pc.
  - If mem_req_ready, go to WAIT next cycle; otherwise stay in REQ.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid, inst_reg<=mem_resp_inst and go to ISSUE.
- ISSUE:
  - query_pc=pc, query_inst=inst_reg.
  - out_valid=1, out_inst=inst_reg, out_pc=pc, out_pred_jump=predicted_jump.
  - If dec_ready: pc<=predicted_jump ? pc+predicted_imm : pc+4, modulo 2^ADDR_W with wrap-around and no overflow flag; go to REQ.
  - If dec_ready is low, hold every output stable.
- query_pc and query_inst read 0 outside ISSUE. out_* read 0 when out_valid=0.
- Fetch-to-issue latency: REQ accepted at cycle t, response at t+k (k>=1), out_valid at t+k+1. With dec_ready high, the next REQ is at t+k+2.
- Rollback (rollback_valid with rdy high) has priority over every other event in the same cycle, and pc<=rollback_pc in every case:
  - From REQ whose request is accepted that same cycle: go to DRAIN (the request is in flight).
  - From REQ not accepted: go to REQ.
  - From WAIT with no response that cycle: go to DRAIN.
  - From WAIT with a response that same cycle: discard the response and go to REQ.
  - From ISSUE: go to REQ. The instruction is dropped even if dec_ready is high that cycle. out_valid must not be seen by the decoder as accepted: the decoder ignores acceptance when rollback_valid is high.
  - From DRAIN: stay in DRAIN with the new PC.
- DRAIN:
  - mem_req_valid=0, out_valid=0.
  - On mem_resp_valid, discard the data and go to REQ.
  - A rollback in the same cycle as that response updates pc and still goes to REQ.
- Only one request is ever outstanding. mem_resp_valid outside WAIT/DRAIN is ignored.

Test Plan:
- Reset with RESET_PC=0, mem_req_ready=1, 1-cycle memory returning 32'h00000013:
  - req addr=0, then out_valid with out_pc=0, out_pred_jump=0.
  - Next req addr=4.
- JAL at pc=8 with offset +16 (inst 32'h0100006F), predictor returns jump=1, imm=16:
  - out_pred_jump=1.
  - Next mem_req_addr=24.
- dec_ready held low 5 cycles in ISSUE:
  - out_valid, out_inst and out_pc stay constant; no new request.
  - Advances when dec_ready rises.
- rollback_valid (rollback_pc=32'h100) in WAIT, response arrives 3 cycles later:
  - Response discarded, no out_valid.
  - Next request addr=32'h100.
- rollback in the same cycle as mem_resp_valid in WAIT:
  - Data dropped, state REQ, addr=rollback_pc.
  - Rollback in ISSUE with dec_ready=1: pc=rollback_pc, not pc+4.
- pc=32'hFFFFFFFC, non-jump instruction accepted: next addr=0 (wrap).
  - rdy low for 3 cycles mid-WAIT with a response pulse during rdy low: response ignored and state unchanged.
